// File: rtl/reg_file_scoreboard_pkg.sv
// Shared parameters for the decode-stage register file and its pending-write scoreboard.
//   WIDTH    : data width of each register
//   NUM_REGS : number of architectural registers (all writable)
//   ADDR_W   : register address width, log2(NUM_REGS)
//   CNT_W    : pending-write counter width
//   CNT_MAX  : largest count a pending-write counter can hold
package reg_file_scoreboard_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

endpackage

// File: rtl/rf_pending_counter.sv
// Per-register pending-write counter: saturating up/down with synchronous reset.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_inc          : an instruction writing this register was issued
//   i_dec          : a write-back to this register completed
//   o_count        : current count
//   o_count_next   : count after the coming edge (ignores reset)
//   o_nonzero      : count != 0
//   o_full         : count == maximum
module rf_pending_counter
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned CntW = CNT_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [CntW-1:0] o_count,
  output logic [CntW-1:0] o_count_next,
  output logic            o_nonzero,
  output logic            o_full
);

  logic [CntW-1:0] count_q, count_d;
  logic            inc_eff, dec_eff;

  assign o_nonzero = |count_q;
  assign o_full    = &count_q;

  // Never wrap in either direction; a simultaneous inc and dec cancel.
  assign inc_eff = i_inc & ~o_full;
  assign dec_eff = i_dec & o_nonzero;

  always_comb begin
    count_d = count_q;
    if (inc_eff && !dec_eff) begin
      count_d = count_q + CntW'(1);
    end else if (dec_eff && !inc_eff) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count      = count_q;
  assign o_count_next = count_d;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Decode-stage register file with two registered read ports, one write-back port,
// and a per-register pending-write scoreboard that raises a RAW/full stall.
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_read_enable             : capture read data at this edge
//   i_rs1_addr, i_rs2_addr    : source addresses
//   i_rs1_used, i_rs2_used    : instruction actually reads that source
//   i_issue, i_issue_rd_en,
//   i_issue_rd_addr           : instruction leaving decode and its destination
//   i_wb_enable, i_wb_addr,
//   i_wb_data                 : write-back port
//   o_rs1_data, o_rs2_data    : registered read data (write-back bypassed)
//   o_hazard                  : combinational stall request
//   o_pending_any             : registered, any pending-write counter non-zero
module reg_file_scoreboard #(
  parameter int unsigned WIDTH    = reg_file_scoreboard_pkg::WIDTH,
  parameter int unsigned NUM_REGS = reg_file_scoreboard_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = reg_file_scoreboard_pkg::ADDR_W,
  parameter int unsigned CNT_W    = reg_file_scoreboard_pkg::CNT_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_read_enable,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic              i_issue,
  input  logic              i_issue_rd_en,
  input  logic [ADDR_W-1:0] i_issue_rd_addr,
  input  logic              i_wb_enable,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [WIDTH-1:0]  i_wb_data,
  output logic [WIDTH-1:0]  o_rs1_data,
  output logic [WIDTH-1:0]  o_rs2_data,
  output logic              o_hazard,
  output logic              o_pending_any
);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    rs1_data_q, rs2_data_q;
  logic [WIDTH-1:0]    rs1_fwd, rs2_fwd;
  logic                pending_any_q, pending_any_d;

  logic [CNT_W-1:0]    cnt      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero, full, inc, dec;

  logic                wb_hits_rs1, wb_hits_rs2;
  logic                src1_haz, src2_haz, dst_full;

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    assign inc[r] = i_issue && i_issue_rd_en && (i_issue_rd_addr == ADDR_W'(r)) && !o_hazard;
    assign dec[r] = i_wb_enable && (i_wb_addr == ADDR_W'(r));

    rf_pending_counter #(
      .CntW (CNT_W)
    ) u_cnt (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_inc        (inc[r]),
      .i_dec        (dec[r]),
      .o_count      (cnt[r]),
      .o_count_next (cnt_next[r]),
      .o_nonzero    (nonzero[r]),
      .o_full       (full[r])
    );
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign wb_hits_rs1 = i_wb_enable && (i_wb_addr == i_rs1_addr);
  assign wb_hits_rs2 = i_wb_enable && (i_wb_addr == i_rs2_addr);

  // The last outstanding write landing this cycle is forwarded, so it does not stall.
  assign src1_haz = i_rs1_used && nonzero[i_rs1_addr] &&
                    !(wb_hits_rs1 && (cnt[i_rs1_addr] == CNT_W'(1)));
  assign src2_haz = i_rs2_used && nonzero[i_rs2_addr] &&
                    !(wb_hits_rs2 && (cnt[i_rs2_addr] == CNT_W'(1)));
  assign dst_full = i_issue_rd_en && full[i_issue_rd_addr];

  assign o_hazard = src1_haz | src2_haz | dst_full;

  always_comb begin
    pending_any_d = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_any_d = pending_any_d | (|cnt_next[r]);
    end
  end

  // ---------------------------------------------------------------------------
  // Register array and read ports
  // ---------------------------------------------------------------------------
  assign rs1_fwd = wb_hits_rs1 ? i_wb_data : regs_q[i_rs1_addr];
  assign rs2_fwd = wb_hits_rs2 ? i_wb_data : regs_q[i_rs2_addr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      pending_any_q <= 1'b0;
    end else begin
      if (i_wb_enable) begin
        regs_q[i_wb_addr] <= i_wb_data;
      end
      if (i_read_enable) begin
        rs1_data_q <= rs1_fwd;
        rs2_data_q <= rs2_fwd;
      end
      pending_any_q <= pending_any_d;
    end
  end

  assign o_rs1_data    = rs1_data_q;
  assign o_rs2_data    = rs2_data_q;
  assign o_pending_any = pending_any_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

  logic        clk;
  logic        reset;
  logic        read_enable;
  logic [2:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic        issue, issue_rd_en;
  logic [2:0]  issue_rd_addr;
  logic        wb_enable;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] rs1_data, rs2_data;
  logic        hazard, pending_any;

  int total = 0;
  int bad   = 0;

  reg_file_scoreboard dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_read_enable   (read_enable),
    .i_rs1_addr      (rs1_addr),
    .i_rs2_addr      (rs2_addr),
    .i_rs1_used      (rs1_used),
    .i_rs2_used      (rs2_used),
    .i_issue         (issue),
    .i_issue_rd_en   (issue_rd_en),
    .i_issue_rd_addr (issue_rd_addr),
    .i_wb_enable     (wb_enable),
    .i_wb_addr       (wb_addr),
    .i_wb_data       (wb_data),
    .o_rs1_data      (rs1_data),
    .o_rs2_data      (rs2_data),
    .o_hazard        (hazard),
    .o_pending_any   (pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        wb;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; read_enable = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    issue = 0; issue_rd_en = 0; issue_rd_addr = 0; wb_enable = 0; wb_addr = 0; wb_data = 0;
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [2:0] rd);
    idle();
    issue = 1; issue_rd_en = 1; issue_rd_addr = rd;
  endtask

  task automatic do_wb(input logic [2:0] a, input logic [15:0] d);
    idle();
    wb_enable = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd0, 3'd1, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 3'd4, 3'd5, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 3'd6, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 3'd3, 3'd3, 1'b1, 3'd3, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 3'd3, 3'd5, 1'b1, 3'd5, 16'h1234, 16'hBEEF, 16'h1234};
    vecs[6] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 16'h1111, 16'hBEEF, 16'h1234};
    vecs[7] = '{1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h1111, 16'h1111};
    vecs[8] = '{1'b1, 3'd5, 3'd3, 1'b1, 3'd3, 16'h5555, 16'h1234, 16'h5555};
    vecs[9] = '{1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h5555, 16'h1111};

    idle();
    reset = 1;
    tick();
    tick();
    chk("reset_rs1", 32'(rs1_data), 32'h0);
    chk("reset_rs2", 32'(rs2_data), 32'h0);
    chk("reset_pending", 32'(pending_any), 32'h0);
    idle();

    // Plain reads/writes, bypass and hold; scoreboard is empty throughout.
    for (int i = 0; i < 10; i++) begin
      idle();
      read_enable = vecs[i].re;
      rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
      rs1_used = 1; rs2_used = 1;
      wb_enable = vecs[i].wb; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_hazard", i), 32'(hazard), 32'h0);
      tick();
      chk($sformatf("vec%0d_rs1", i), 32'(rs1_data), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_rs2", i), 32'(rs2_data), 32'(vecs[i].e2));
      chk($sformatf("vec%0d_pending", i), 32'(pending_any), 32'h0);
    end

    // RAW on R2, resolved by the write-back bypass.
    do_issue(3'd2);
    #1 chk("raw_issue_hazard", 32'(hazard), 32'h0);
    tick();
    chk("raw_pending", 32'(pending_any), 32'h1);
    idle(); rs1_addr = 2; rs1_used = 1;
    #1 chk("raw_src1_hazard", 32'(hazard), 32'h1);
    idle(); rs2_addr = 2; rs2_used = 1;
    #1 chk("raw_src2_hazard", 32'(hazard), 32'h1);
    idle(); rs2_addr = 2; rs2_used = 0;
    #1 chk("raw_unused_nohaz", 32'(hazard), 32'h0);
    do_wb(3'd2, 16'h00AA); read_enable = 1; rs1_addr = 2; rs1_used = 1;
    #1 chk("raw_wb_nohaz", 32'(hazard), 32'h0);
    tick();
    chk("raw_rs1_data", 32'(rs1_data), 32'h00AA);
    chk("raw_cleared", 32'(pending_any), 32'h0);
    idle(); rs1_addr = 2; rs1_used = 1;
    #1 chk("raw_after_hazard", 32'(hazard), 32'h0);

    // Saturation on R4.
    for (int k = 0; k < 3; k++) begin
      do_issue(3'd4);
      #1 chk($sformatf("sat_issue%0d_hazard", k), 32'(hazard), 32'h0);
      tick();
    end
    do_issue(3'd4);
    #1 chk("sat_full_hazard", 32'(hazard), 32'h1);
    tick();
    chk("sat_pending", 32'(pending_any), 32'h1);
    do_issue(3'd4);
    #1 chk("sat_still_full", 32'(hazard), 32'h1);
    do_wb(3'd4, 16'h4441); rs1_addr = 4; rs1_used = 1;
    #1 chk("sat_wb3_hazard", 32'(hazard), 32'h1);
    tick();
    do_wb(3'd4, 16'h4442);
    tick();
    chk("sat_wb2_pending", 32'(pending_any), 32'h1);
    do_wb(3'd4, 16'h4443); rs1_addr = 4; rs1_used = 1;
    #1 chk("sat_wb1_nohaz", 32'(hazard), 32'h0);
    tick();
    chk("sat_drained", 32'(pending_any), 32'h0);

    // Same-edge issue and write-back on R6 leaves count at 1.
    do_issue(3'd6);
    tick();
    do_issue(3'd6); wb_enable = 1; wb_addr = 6; wb_data = 16'h6666;
    #1 chk("r6_both_hazard", 32'(hazard), 32'h0);
    tick();
    chk("r6_pending", 32'(pending_any), 32'h1);
    idle(); rs1_addr = 6; rs1_used = 1;
    #1 chk("r6_still_pending", 32'(hazard), 32'h1);
    do_wb(3'd6, 16'h6667);
    tick();
    chk("r6_cleared", 32'(pending_any), 32'h0);

    // Write-back to R7 with no pending write.
    do_wb(3'd7, 16'h7777);
    tick();
    chk("r7_no_underflow", 32'(pending_any), 32'h0);
    idle(); read_enable = 1; rs1_addr = 7; rs2_addr = 6; rs1_used = 1; rs2_used = 1;
    #1 chk("r7_hazard", 32'(hazard), 32'h0);
    tick();
    chk("r7_data", 32'(rs1_data), 32'h7777);
    chk("r6_data", 32'(rs2_data), 32'h6667);

    // Reset mid-flight with R1 count 2 overrides write-back and issue.
    do_issue(3'd1);
    tick();
    do_issue(3'd1);
    tick();
    chk("mid_pending", 32'(pending_any), 32'h1);
    do_wb(3'd1, 16'hFFFF); reset = 1; issue = 1; issue_rd_en = 1; issue_rd_addr = 1;
    read_enable = 1; rs1_addr = 1;
    tick();
    chk("mid_rst_rs1", 32'(rs1_data), 32'h0);
    chk("mid_rst_rs2", 32'(rs2_data), 32'h0);
    chk("mid_rst_pending", 32'(pending_any), 32'h0);
    idle(); read_enable = 1; rs1_addr = 1; rs2_addr = 7; rs1_used = 1; rs2_used = 1;
    #1 chk("mid_rst_hazard", 32'(hazard), 32'h0);
    tick();
    chk("mid_rst_r1", 32'(rs1_data), 32'h0);
    chk("mid_rst_r7", 32'(rs2_data), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
